// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter, one registered stage per shift-amount bit.
// Optional rotate logic under `BARREL_SHIFT_PIPE_ROTATE_EN`.
//
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   in_valid/ready  operand handshake (din, shift, dir, mode)
//   din [WIDTH]     operand
//   shift [SHW]     shift amount 0..WIDTH-1
//   dir             0 = left, 1 = right
//   mode [2]        00 logical, 01 arith, 10 rotate, 11 logical
//   out_valid/ready result handshake
//   dout [WIDTH]    result, the last stage data register
`timescale 1ns/1ps

module barrel_shift_pipe #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shift,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   amt;
    logic             dir;
    logic [1:0]       mode;
    logic             sign;
  } stage_t;

  // One conditional shift by n positions.
  // sign is the operand's original MSB, carried
  // so arithmetic fill never depends on partial data.
  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] d,
    input int               n,
    input logic             right,
    input logic [1:0]       op,
    input logic             sign
  );
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] top;
    logic             arith;
    logic             rot;
    arith = (op == 2'b01) && right;
`ifdef BARREL_SHIFT_PIPE_ROTATE_EN
    rot = (op == 2'b10);
`else
    rot = 1'b0;
`endif
    top = ~({WIDTH{1'b1}} >> n);
    if (right) begin
      r = d >> n;
      if (arith) r = r | (top & {WIDTH{sign}});
`ifdef BARREL_SHIFT_PIPE_ROTATE_EN
      if (rot) r = r | (d << (WIDTH - n));
`endif
    end else begin
      r = d << n;
`ifdef BARREL_SHIFT_PIPE_ROTATE_EN
      if (rot) r = r | (d >> (WIDTH - n));
`endif
    end
    if (rot && arith) r = '0;
    return r;
  endfunction

  logic   advance;
  stage_t head;
  stage_t last;

  // All stages move together; a full stall
  // freezes every register including bubbles.
  assign advance  = !last.valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    head       = '0;
    head.valid = in_valid;
    head.data  = din;
    head.amt   = shift;
    head.dir   = dir;
    head.mode  = mode;
    head.sign  = din[WIDTH-1];
  end

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    stage_t src;
    stage_t nxt;
    stage_t q;

    if (k == 0) begin : g_head
      assign src = head;
    end else begin : g_link
      assign src = g_stage[k-1].q;
    end

    always_comb begin
      nxt = src;
      if (src.amt[k]) begin
        nxt.data = step(src.data, 1 << k,
                        src.dir, src.mode,
                        src.sign);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q <= '0;
      end else if (advance) begin
        q <= nxt;
      end
    end
  end

  assign last      = g_stage[SHW-1].q;
  assign out_valid = last.valid;
  assign dout      = last.data;

  // Control fields of the last stage have no consumer.
  logic unused_tail;
  assign unused_tail = ^{last.amt, last.dir,
                         last.mode, last.sign};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe (WIDTH = 8).
// Reference model + scoreboard, plus literal directed checks.
`timescale 1ns/1ps

module tb_barrel_shift_pipe;

  localparam int W = 8;
`ifdef BARREL_SHIFT_PIPE_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic         clk = 0;
  logic         rst = 1;
  logic         in_valid = 0;
  logic         in_ready;
  logic [W-1:0] din = '0;
  logic [2:0]   shift = '0;
  logic         dir = 0;
  logic [1:0]   mode = '0;
  logic         out_valid;
  logic         out_ready = 0;
  logic [W-1:0] dout;

  int total = 0;
  int bad = 0;
  int accepted = 0;
  int retired = 0;
  bit rand_ready = 0;
  bit prev_stall = 0;
  logic [W-1:0] prev_dout;
  logic [W-1:0] q[$];

  barrel_shift_pipe #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .din(din),
    .shift(shift),
    .dir(dir),
    .mode(mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout(dout)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(
    input logic [W-1:0] d, input int n,
    input logic right, input logic [1:0] m);
    logic [W-1:0] r;
    if (m == 2'b10 && ROT) begin
      if (right) r = (d >> n) | (d << (W - n));
      else       r = (d << n) | (d >> (W - n));
    end else if (m == 2'b01 && right) begin
      r = $signed(d) >>> n;
    end else if (right) begin
      r = d >> n;
    end else begin
      r = d << n;
    end
    return r;
  endfunction

  task automatic check(input string name,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge rst) begin
    q.delete();
    accepted = 0;
    retired = 0;
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(3) != 0);
    end
  end

  // Cycle-wise compare process.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      check("in_ready_rule", {7'd0, in_ready},
            {7'd0, (!out_valid || out_ready)});
      if (prev_stall) begin
        check("stall_valid", {7'd0, out_valid}, 8'd1);
        check("stall_dout", dout, prev_dout);
      end
      if (out_valid && out_ready) begin
        retired++;
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious: got %h want none", dout);
        end else begin
          check("scoreboard", dout, q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(din, int'(shift), dir, mode));
        accepted++;
      end
      prev_stall = out_valid && !out_ready;
      prev_dout = dout;
    end
  end

  task automatic drive(input logic [W-1:0] d,
                       input logic [2:0] s,
                       input logic dr,
                       input logic [1:0] m);
    bit acc;
    int n;
    din = d; shift = s; dir = dr; mode = m;
    in_valid = 1; acc = 0; n = 0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 0;
    din = W'($urandom);
    shift = 3'($urandom);
    dir = 1'($urandom);
    mode = 2'($urandom);
    check("accept_bound", {7'd0, acc}, 8'd1);
  endtask

  task automatic send_one(input logic [2:0] s,
                          input logic dr,
                          input logic [1:0] m,
                          input logic [W-1:0] exp,
                          input string name);
    int lat;
    drive(8'h96, s, dr, m);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_lat"}, W'(lat), 8'd3);
    check(name, dout, exp);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", W'(q.size()), 8'd0);
  endtask

  logic [W-1:0] seq_exp[8] = '{8'h96, 8'hCB, 8'hE5,
    8'hF2, 8'hF9, 8'hFC, 8'hFE, 8'hFF};

  initial begin
    logic [W-1:0] held;
    int n;

    check("pin_model_l", model(8'h96, 3, 0, 2'b00), 8'hB0);
    check("pin_model_a", model(8'h96, 3, 1, 2'b01), 8'hF2);
    check("pin_model_r", model(8'h96, 3, 1, 2'b00), 8'h12);

    repeat (2) @(negedge clk);
    check("rst_valid", {7'd0, out_valid}, 8'd0);
    check("rst_dout", dout, 8'h00);
    check("rst_ready", {7'd0, in_ready}, 8'd1);
    rst = 0;
    out_ready = 1;
    repeat (3) @(negedge clk);
    check("idle_valid", {7'd0, out_valid}, 8'd0);
    check("idle_dout", dout, 8'h00);
    @(posedge clk); #1;

    send_one(3, 0, 2'b00, 8'hB0, "lsl3");
    send_one(3, 1, 2'b00, 8'h12, "lsr3");
    send_one(3, 1, 2'b01, 8'hF2, "asr3");
    send_one(3, 0, 2'b01, 8'hB0, "asl3");
    send_one(0, 1, 2'b01, 8'h96, "zero_shift");
    send_one(3, 0, 2'b10, ROT ? 8'hB4 : 8'hB0, "rol3");
    send_one(3, 1, 2'b10, ROT ? 8'hD2 : 8'h12, "ror3");
    send_one(3, 1, 2'b11, 8'h12, "resv3");
    drain();

    fork
      begin
        for (int i = 0; i < 8; i++)
          drive(8'h96, 3'(i), 1, 2'b01);
      end
      begin
        n = 0;
        while (!out_valid && n < 20) begin
          @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 8; i++) begin
          check("b2b_valid", {7'd0, out_valid}, 8'd1);
          check("b2b_dout", dout, seq_exp[i]);
          @(posedge clk); #1;
        end
      end
    join
    drain();

    fork
      begin
        for (int i = 0; i < 5; i++)
          drive(W'($urandom), 3'($urandom),
                1'($urandom), 2'($urandom));
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 0;
        @(negedge clk);
        held = dout;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("bp_valid", {7'd0, out_valid}, 8'd1);
          check("bp_ready", {7'd0, in_ready}, 8'd0);
          check("bp_dout", dout, held);
        end
        @(posedge clk); #1;
        out_ready = 1;
      end
    join
    drain();
    check("bp_count", W'(accepted - retired), 8'd0);

    for (int i = 0; i < 3; i++)
      drive(8'h96, 3'(i + 1), 0, 2'b00);
    #2 rst = 1;
    #1;
    check("async_rst_valid", {7'd0, out_valid}, 8'd0);
    check("async_rst_dout", dout, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_valid", {7'd0, out_valid}, 8'd0);
    end
    @(posedge clk); #1;

    rand_ready = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(3) == 0) begin
        @(posedge clk); #1;
      end
      drive(W'($urandom), 3'($urandom),
            1'($urandom), 2'($urandom));
    end
    rand_ready = 0;
    @(posedge clk); #1;
    out_ready = 1;
    drain();
    total++;
    if (accepted != retired || accepted < 10000) begin
      bad++;
      $display("FAIL rand_count: got %0d retired want %0d",
               retired, accepted);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
